// File: rtl/div_fsm_pkg.sv
// rtl/div_fsm_pkg.sv - shared state encoding and divisor bounds for the clock divider FSM
package div_fsm_pkg;

    // Legal range of the DIVISOR parameter (inclusive)
    localparam int DIVISOR_MIN = 2;
    localparam int DIVISOR_MAX = 16;

    // Named states of the default divide-by-3 configuration
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_t;

    // State entered on reset and on recovery from any unused encoding
    localparam state_t RESET_STATE = S0;

endpackage

// File: rtl/divide_by_3_fsm.sv
// rtl/divide_by_3_fsm.sv - Moore FSM producing a one-cycle strobe every DIVISOR clocks
module divide_by_3_fsm
    import div_fsm_pkg::*;
#(
    parameter int DIVISOR = 3,
    parameter int SW      = $clog2(DIVISOR)
) (
    input  logic clk,
    input  logic rst,
    output logic y
);

    // Out-of-range divisors are rejected at elaboration
    if (DIVISOR < DIVISOR_MIN || DIVISOR > DIVISOR_MAX) begin : g_bad_divisor
        $error("divide_by_3_fsm: DIVISOR out of legal range");
    end

    // S0 is the strobe state; the last state wraps back to it
    localparam logic [SW-1:0] S0_CODE   = SW'(RESET_STATE);
    localparam logic [SW-1:0] LAST_CODE = SW'(DIVISOR - 1);

    logic [SW-1:0] state_q;
    logic [SW-1:0] next_state;

    // State register; low rst forces S0 immediately without waiting for clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S0_CODE;
        end else begin
            state_q <= next_state;
        end
    end

    // Advance one state per clock; the last state and any unused code go to S0
    always_comb begin
        next_state = S0_CODE;
        if (state_q < LAST_CODE) begin
            next_state = state_q + SW'(1);
        end
    end

    // Moore output decoded from the state register alone
    always_comb begin
        y = 1'b0;
        if (state_q == S0_CODE) begin
            y = 1'b1;
        end
    end

endmodule

// File: tb/tb_divide_by_3_fsm.sv
// tb/tb_divide_by_3_fsm.sv - directed scoreboard bench for divide_by_3_fsm
module tb_divide_by_3_fsm;

    logic clk;
    logic rst;
    logic y3;
    logic y2;
    logic y5;

    int checks;
    int failures;

    typedef struct {
        int   dut;
        logic exp;
    } exp_t;

    exp_t sb[$];

    int n2;
    int n5;

    divide_by_3_fsm dut3 (
        .clk (clk),
        .rst (rst),
        .y   (y3)
    );

    divide_by_3_fsm #(.DIVISOR(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .y   (y2)
    );

    divide_by_3_fsm #(.DIVISOR(5)) dut5 (
        .clk (clk),
        .rst (rst),
        .y   (y5)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic y_of(input int idx);
        case (idx)
            0:       return y3;
            1:       return y2;
            default: return y5;
        endcase
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Push expectations for one edge, take the edge, sample 7 ns later and compare
    task automatic cycle_check(input logic e3);
        exp_t e;
        e.dut = 0; e.exp = e3;                           sb.push_back(e);
        e.dut = 1; e.exp = ((n2 + 1) % 2 == 0) ? 1'b1 : 1'b0; sb.push_back(e);
        e.dut = 2; e.exp = ((n5 + 1) % 5 == 0) ? 1'b1 : 1'b0; sb.push_back(e);
        n2++;
        n5++;
        @(posedge clk);
        #7;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                0:       check("y_div3", y_of(0), e.exp);
                1:       check("y_div2", y_of(1), e.exp);
                default: check("y_div5", y_of(2), e.exp);
            endcase
        end
    endtask

    logic pat3 [0:2];
    int   highs3;
    int   highs2;
    int   highs5;
    int   consec3;
    logic prev3;

    initial begin
        checks   = 0;
        failures = 0;
        n2       = 0;
        n5       = 0;
        pat3[0]  = 1'b0;
        pat3[1]  = 1'b0;
        pat3[2]  = 1'b1;

        // Reset hold, including across the edge at 5 ns
        rst = 1'b0;
        #2;
        check("reset_y_div3", y3, 1'b1);
        check("reset_y_div2", y2, 1'b1);
        check("reset_y_div5", y5, 1'b1);
        #8;
        check("reset_hold_y", y3, 1'b1);
        check_int("reset_hold_state", int'(dut3.state_q), 0);

        // Release at 12 ns, steady sequence over 12 cycles
        #2;
        rst = 1'b1;
        n2 = 0;
        n5 = 0;
        for (int i = 0; i < 12; i++) begin
            cycle_check(pat3[i % 3]);
        end

        // Step into S1, then reset asynchronously between edges
        cycle_check(1'b0);
        check_int("in_s1_state", int'(dut3.state_q), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_y_div3", y3, 1'b1);
        check("async_reset_y_div2", y2, 1'b1);
        check("async_reset_y_div5", y5, 1'b1);
        #5;
        check("reset_hold_edge_y", y3, 1'b1);
        #2;
        rst = 1'b1;
        n2 = 0;
        n5 = 0;
        for (int i = 0; i < 3; i++) begin
            cycle_check(pat3[i]);
        end

        // Unused encoding 3 recovers to S0 on the next edge
        force dut3.state_q = 2'd3;
        #1;
        release dut3.state_q;
        check_int("illegal_state_forced", int'(dut3.state_q), 3);
        check("illegal_state_y", y3, 1'b0);
        cycle_check(1'b1);
        check_int("illegal_recovered_state", int'(dut3.state_q), 0);
        for (int i = 0; i < 3; i++) begin
            cycle_check(pat3[i]);
        end

        // Duty check over 300 clocks after a fresh reset release
        rst = 1'b0;
        #1;
        rst = 1'b1;
        n2 = 0;
        n5 = 0;
        highs3  = 0;
        highs2  = 0;
        highs5  = 0;
        consec3 = 0;
        prev3   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cycle_check(pat3[i % 3]);
            if (y3 === 1'b1) highs3++;
            if (y2 === 1'b1) highs2++;
            if (y5 === 1'b1) highs5++;
            if (y3 === 1'b1 && prev3 === 1'b1) consec3++;
            prev3 = y3;
        end
        check_int("duty_highs_div3", highs3, 100);
        check_int("duty_consecutive_div3", consec3, 0);
        check_int("duty_highs_div2", highs2, 150);
        check_int("duty_highs_div5", highs5, 60);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
